// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB definitions for the arbiter slice.
//   - HTRANS, HBURST and HRESP encodings as typed enums
//   - arbiter FSM state type
//   - burst_beats(): number of beats implied by an HBURST code
//     (0 means undefined-length INCR, which never counts down)
// ---------------------------------------------------------------------------
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    // ARB: handover allowed; BURST: fixed-length burst in flight;
    // LOCKED: the address-phase owner holds HLOCK.
    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_BURST  = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_e;

    // Every slave drives a 16-bit split-release vector.
    localparam int SPLIT_W = 16;

    // Beats in a burst: 1 for SINGLE, 4/8/16 for the fixed-length kinds,
    // 0 for undefined-length INCR.
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HBURST_SINGLE:               burst_beats = 5'd1;
            HBURST_WRAP4,  HBURST_INCR4:  burst_beats = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  burst_beats = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: burst_beats = 5'd16;
            default:                     burst_beats = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// ---------------------------------------------------------------------------
// ahb_rr_picker
// Combinational request picker.
//   mode = 0 : rotating priority, scanning ptr+1, ptr+2, ... wrapping,
//              with ptr itself examined last
//   mode = 1 : fixed priority, lowest set index wins
// Ports
//   req  [N]  request vector
//   ptr  [MW] index of the previous winner (rotating mode only)
//   mode      0 = rotating, 1 = fixed
//   gnt  [N]  one-hot winner, all zero when req is zero
//   idx  [MW] winner index, zero when req is zero
// ---------------------------------------------------------------------------
module ahb_rr_picker #(
    parameter int N  = 4,
    parameter int MW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [MW-1:0] ptr,
    input  logic          mode,
    output logic [N-1:0]  gnt,
    output logic [MW-1:0] idx
);

    // Walk the N candidates in priority order and take the first one that
    // requests. The candidate order depends on the mode; the wrap is done
    // with a compare-and-subtract so non power-of-two N works too.
    always_comb begin
        int   cand;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= N; k++) begin
            if (mode) begin
                cand = k - 1;
            end else begin
                cand = int'(ptr) + k;
                if (cand >= N) begin
                    cand = cand - N;
                end
            end
            if (!found && req[cand[MW-1:0]]) begin
                gnt[cand[MW-1:0]] = 1'b1;
                idx               = cand[MW-1:0];
                found             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter_rr.sv
// ---------------------------------------------------------------------------
// ahb_arbiter_rr
// Parametrised AHB arbiter for NUM_MST masters with round-robin or fixed
// priority, burst-length-aware handover, HLOCK support and SPLIT masking.
// Parameters
//   NUM_MST      number of masters (2..16)
//   NUM_SLV      number of SPLIT-capable slaves
//   PRIO_MODE    0 = round-robin after the last owner, 1 = lowest index wins
//   DEFAULT_MST  master granted when nobody is eligible
// Ports
//   hclk, hreset          clock and asynchronous active-high reset
//   hbusreq, hlock        per-master request and locked-transfer request
//   htrans, hburst        muxed transfer type / burst kind of the owner
//   hready, hresp         bus handshake and response
//   hsplit                split-release vectors, slave s at [16s+15:16s]
//   hgrant                registered one-hot grant
//   hmaster               registered address-phase owner index
//   hmastlock             registered "current transfer is locked"
// ---------------------------------------------------------------------------
module ahb_arbiter_rr
    import ahb_pkg::*;
#(
    parameter int NUM_MST     = 4,
    parameter int NUM_SLV     = 4,
    parameter int PRIO_MODE   = 0,
    parameter int DEFAULT_MST = 0,
    localparam int MW         = $clog2(NUM_MST)
) (
    input  logic                       hclk,
    input  logic                       hreset,
    input  logic [NUM_MST-1:0]         hbusreq,
    input  logic [NUM_MST-1:0]         hlock,
    input  logic [1:0]                 htrans,
    input  logic [2:0]                 hburst,
    input  logic                       hready,
    input  logic [1:0]                 hresp,
    input  logic [NUM_SLV*SPLIT_W-1:0] hsplit,
    output logic [NUM_MST-1:0]         hgrant,
    output logic [MW-1:0]              hmaster,
    output logic                       hmastlock
);

    localparam logic [NUM_MST-1:0] ONE_HOT0 = {{(NUM_MST-1){1'b0}}, 1'b1};
    localparam logic [NUM_MST-1:0] DEF_GNT  = ONE_HOT0 << DEFAULT_MST;
    localparam logic [MW-1:0]      DEF_IDX  = MW'(DEFAULT_MST);

    arb_state_e           state, state_d;
    logic [3:0]           beat_cnt, beat_d;
    logic [NUM_MST-1:0]   split_mask, split_d;
    logic [MW-1:0]        last_owner, last_d;
    logic [MW-1:0]        grant_idx, gidx_d;
    logic [NUM_MST-1:0]   grant_d;
    logic [MW-1:0]        master_d;
    logic                 mlock_d;

    logic [NUM_MST-1:0]   elig;
    logic [NUM_MST-1:0]   pick_gnt;
    logic [MW-1:0]        pick_idx;
    logic [SPLIT_W-1:0]   split_or;
    logic [NUM_MST-1:0]   split_clr;
    logic                 unused_split_or;
    logic [4:0]           beats;
    logic                 owner_keeps;
    logic                 split_hit;

    // OR the release vectors of all slaves together; only the low NUM_MST
    // bits name real masters, the rest are folded into a dummy net.
    always_comb begin
        split_or = '0;
        for (int s = 0; s < NUM_SLV; s++) begin
            split_or = split_or | hsplit[s*SPLIT_W +: SPLIT_W];
        end
    end

    assign split_clr       = split_or[NUM_MST-1:0];
    assign unused_split_or = ^split_or;

    assign elig  = hbusreq & ~split_mask;
    assign beats = burst_beats(hburst);

    // The owner only keeps the bus while it is mid-transfer and still
    // eligible; IDLE/BUSY or dropping its request opens a handover.
    assign owner_keeps = elig[hmaster] &&
                         (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);

    // First cycle of a two-cycle SPLIT response.
    assign split_hit = (hresp == HRESP_SPLIT) && !hready;

    ahb_rr_picker #(
        .N  (NUM_MST),
        .MW (MW)
    ) u_picker (
        .req  (elig),
        .ptr  (last_owner),
        .mode (PRIO_MODE == 1),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

    // Next-state logic. Grant decisions, hmaster/hmastlock updates and FSM
    // transitions all happen only on hready=1 edges; a SPLIT first cycle
    // (hready=0) is the one exception: it aborts BURST/LOCKED and masks the
    // owner so the next decision moves the grant elsewhere. Grant and
    // hmaster are frozen outside ARB, so the handover waits for the burst or
    // lock to finish.
    always_comb begin
        state_d  = state;
        beat_d   = beat_cnt;
        grant_d  = hgrant;
        gidx_d   = grant_idx;
        master_d = hmaster;
        last_d   = last_owner;
        mlock_d  = hmastlock;

        if (state == ST_ARB && hready) begin
            if (owner_keeps) begin
                grant_d = ONE_HOT0 << hmaster;
                gidx_d  = hmaster;
            end else if (elig == '0) begin
                grant_d = DEF_GNT;
                gidx_d  = DEF_IDX;
            end else begin
                grant_d = pick_gnt;
                gidx_d  = pick_idx;
            end
            master_d = grant_idx;
            last_d   = grant_idx;
            mlock_d  = hlock[grant_idx];
        end

        if (hready) begin
            case (state)
                ST_ARB: begin
                    if (htrans == HTRANS_NONSEQ && beats > 5'd1) begin
                        state_d = ST_BURST;
                        beat_d  = 4'(beats - 5'd1);
                    end else if (hlock[hmaster]) begin
                        state_d = ST_LOCKED;
                    end
                end
                ST_BURST: begin
                    if (htrans == HTRANS_SEQ) begin
                        beat_d = beat_cnt - 4'd1;
                        if (beat_cnt == 4'd1) begin
                            state_d = ST_ARB;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (!hlock[hmaster] && htrans == HTRANS_IDLE) begin
                        state_d = ST_ARB;
                    end
                end
                default: state_d = ST_ARB;
            endcase
        end

        if (split_hit) begin
            state_d = ST_ARB;
            beat_d  = '0;
        end

        // A release in the same cycle as a new SPLIT wins.
        split_d = (split_mask | (split_hit ? (ONE_HOT0 << hmaster) : '0)) & ~split_clr;
    end

    // State and output registers; reset drops any burst or lock in flight
    // and hands the bus to the default master.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state      <= ST_ARB;
            beat_cnt   <= '0;
            split_mask <= '0;
            last_owner <= DEF_IDX;
            grant_idx  <= DEF_IDX;
            hgrant     <= DEF_GNT;
            hmaster    <= DEF_IDX;
            hmastlock  <= 1'b0;
        end else begin
            state      <= state_d;
            beat_cnt   <= beat_d;
            split_mask <= split_d;
            last_owner <= last_d;
            grant_idx  <= gidx_d;
            hgrant     <= grant_d;
            hmaster    <= master_d;
            hmastlock  <= mlock_d;
        end
    end

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_ahb_arbiter_rr
// Drives a round-robin and a fixed-priority arbiter from the same inputs and
// compares both against a behavioural reference model kept in this file.
// ---------------------------------------------------------------------------
module tb_ahb_arbiter_rr;

    localparam int NM = 4;
    localparam int NS = 4;

    logic            hclk;
    logic            hreset;
    logic [NM-1:0]   hbusreq;
    logic [NM-1:0]   hlock;
    logic [1:0]      htrans;
    logic [2:0]      hburst;
    logic            hready;
    logic [1:0]      hresp;
    logic [NS*16-1:0] hsplit;

    logic [NM-1:0]   hgrant_rr, hgrant_fx;
    logic [1:0]      hmaster_rr, hmaster_fx;
    logic            hmastlock_rr, hmastlock_fx;

    int checks = 0;
    int errors = 0;

    ahb_arbiter_rr #(
        .NUM_MST(NM), .NUM_SLV(NS), .PRIO_MODE(0), .DEFAULT_MST(0)
    ) dut_rr (
        .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock),
        .htrans(htrans), .hburst(hburst), .hready(hready), .hresp(hresp),
        .hsplit(hsplit), .hgrant(hgrant_rr), .hmaster(hmaster_rr),
        .hmastlock(hmastlock_rr)
    );

    ahb_arbiter_rr #(
        .NUM_MST(NM), .NUM_SLV(NS), .PRIO_MODE(1), .DEFAULT_MST(0)
    ) dut_fx (
        .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock),
        .htrans(htrans), .hburst(hburst), .hready(hready), .hresp(hresp),
        .hsplit(hsplit), .hgrant(hgrant_fx), .hmaster(hmaster_fx),
        .hmastlock(hmastlock_fx)
    );

    // Free-running bus clock.
    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    // Reference model, one slot per arbiter (0 = round-robin, 1 = fixed).
    // The bus phase is tracked as "beats still to come" plus a lock flag.
    int m_gnt[2];
    int m_master[2];
    int m_last[2];
    int m_beats[2];
    bit m_locked[2];
    bit m_mastlock[2];
    bit [NM-1:0] m_mask[2];
    int burst_len[8] = '{1, 0, 4, 4, 8, 8, 16, 16};

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            m_gnt[k]      = 0;
            m_master[k]   = 0;
            m_last[k]     = 0;
            m_beats[k]    = 0;
            m_locked[k]   = 1'b0;
            m_mastlock[k] = 1'b0;
            m_mask[k]     = '0;
        end
    endtask

    // Advance model k by one clock edge using the inputs present at that edge.
    task automatic modelStep(input int k);
        bit [NM-1:0] elig;
        bit [NM-1:0] clr;
        bit          free;
        int          win;
        int          cand;
        int          old_master;
        int          nb;
        bit          nl;
        elig       = hbusreq & ~m_mask[k];
        free       = (m_beats[k] == 0) && !m_locked[k];
        old_master = m_master[k];
        nb         = m_beats[k];
        nl         = m_locked[k];
        if (hready && free) begin
            win = -1;
            if (elig[old_master] && (htrans == 2 || htrans == 3)) begin
                win = old_master;
            end else if (elig == 0) begin
                win = 0;
            end else if (k == 1) begin
                for (int i = 0; i < NM; i++)
                    if (win < 0 && elig[i]) win = i;
            end else begin
                for (int s = 1; s <= NM; s++) begin
                    cand = (m_last[k] + s) % NM;
                    if (win < 0 && elig[cand]) win = cand;
                end
            end
            m_mastlock[k] = hlock[m_gnt[k]];
            m_master[k]   = m_gnt[k];
            m_last[k]     = m_gnt[k];
            m_gnt[k]      = win;
        end
        if (hready) begin
            if (free) begin
                if (htrans == 2 && burst_len[hburst] > 1) nb = burst_len[hburst] - 1;
                else if (hlock[old_master]) nl = 1'b1;
            end else if (m_beats[k] > 0) begin
                if (htrans == 3) nb = m_beats[k] - 1;
            end else if (!hlock[old_master] && htrans == 0) begin
                nl = 1'b0;
            end
        end
        if (hresp == 2'b11 && !hready) begin
            nb = 0;
            nl = 1'b0;
            m_mask[k][old_master] = 1'b1;
        end
        clr = '0;
        for (int s = 0; s < NS; s++) clr = clr | hsplit[s*16 +: NM];
        m_mask[k]   = m_mask[k] & ~clr;
        m_beats[k]  = nb;
        m_locked[k] = nl;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkAgainstModel();
        checkOutput("rr_hgrant",    32'(hgrant_rr),    32'(1) << m_gnt[0]);
        checkOutput("rr_hmaster",   32'(hmaster_rr),   32'(m_master[0]));
        checkOutput("rr_hmastlock", 32'(hmastlock_rr), 32'(m_mastlock[0]));
        checkOutput("rr_onehot",    32'($onehot(hgrant_rr)), 32'(1));
        checkOutput("fx_hgrant",    32'(hgrant_fx),    32'(1) << m_gnt[1]);
        checkOutput("fx_hmaster",   32'(hmaster_fx),   32'(m_master[1]));
        checkOutput("fx_hmastlock", 32'(hmastlock_fx), 32'(m_mastlock[1]));
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model and
    // compare just after the edge.
    task automatic applyStimulus(input logic [NM-1:0] req, input logic [NM-1:0] lck,
                                 input logic [1:0] trans, input logic [2:0] burst,
                                 input logic rdy, input logic [1:0] resp,
                                 input logic [NS*16-1:0] split);
        hbusreq = req;
        hlock   = lck;
        htrans  = trans;
        hburst  = burst;
        hready  = rdy;
        hresp   = resp;
        hsplit  = split;
        @(posedge hclk);
        modelStep(0);
        modelStep(1);
        #1;
        checkAgainstModel();
    endtask

    task automatic resetChecks(input string tag);
        checkOutput({tag, "_rr_hgrant"},  32'(hgrant_rr),    32'h1);
        checkOutput({tag, "_rr_hmaster"}, 32'(hmaster_rr),   32'h0);
        checkOutput({tag, "_rr_lock"},    32'(hmastlock_rr), 32'h0);
        checkOutput({tag, "_fx_hgrant"},  32'(hgrant_fx),    32'h1);
    endtask

    localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SGL = 3'd0, INCR8 = 3'd5, INCR16 = 3'd7;
    localparam logic [NS*16-1:0] NOSPL = '0;

    initial begin
        int seq_code;
        int changes;
        logic [1:0] prev;

        hreset  = 1'b1;
        hbusreq = '0;
        hlock   = '0;
        htrans  = IDLE;
        hburst  = SGL;
        hready  = 1'b1;
        hresp   = 2'b00;
        hsplit  = '0;
        modelReset();
        #12;
        resetChecks("reset");
        @(negedge hclk);
        hreset = 1'b0;

        // Round-robin rotation with everybody requesting and idling.
        $display("[TB] round-robin rotation");
        seq_code = 0;
        changes  = 0;
        prev     = hmaster_rr;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(4'hF, 4'h0, IDLE, SGL, 1'b1, 2'b00, NOSPL);
            if (hmaster_rr != prev && changes < 5) begin
                seq_code = seq_code * 16 + int'(hmaster_rr);
                changes++;
            end
            prev = hmaster_rr;
        end
        checkOutput("rr_sequence", 32'(seq_code), 32'h12301);

        // Fixed priority: lowest requester wins, nobody -> default master.
        $display("[TB] fixed priority");
        repeat (2) applyStimulus(4'b1010, 4'h0, IDLE, SGL, 1'b1, 2'b00, NOSPL);
        checkOutput("fixed_1010", 32'(hgrant_fx), 32'b0010);
        applyStimulus(4'b0000, 4'h0, IDLE, SGL, 1'b1, 2'b00, NOSPL);
        checkOutput("fixed_none", 32'(hgrant_fx), 32'b0001);

        // M2 runs an INCR8 burst while M0 keeps requesting.
        $display("[TB] INCR8 burst");
        repeat (3) applyStimulus(4'b0100, 4'h0, IDLE, SGL, 1'b1, 2'b00, NOSPL);
        applyStimulus(4'b0101, 4'h0, NSEQ, INCR8, 1'b1, 2'b00, NOSPL);
        for (int b = 0; b < 7; b++) begin
            applyStimulus(4'b0101, 4'h0, SEQ, INCR8, 1'b1, 2'b00, NOSPL);
            checkOutput("burst_hold", 32'(hgrant_rr), 32'b0100);
        end
        applyStimulus(4'b0101, 4'h0, IDLE, SGL, 1'b1, 2'b00, NOSPL);
        checkOutput("burst_handover", 32'(hgrant_rr), 32'b0001);

        // M1 gets SPLIT, loses the bus, then is released by slave 0.
        $display("[TB] split");
        repeat (3) applyStimulus(4'b0010, 4'h0, IDLE, SGL, 1'b1, 2'b00, NOSPL);
        applyStimulus(4'b0011, 4'h0, NSEQ, SGL, 1'b1, 2'b00, NOSPL);
        applyStimulus(4'b0011, 4'h0, IDLE, SGL, 1'b0, 2'b11, NOSPL);
        applyStimulus(4'b0011, 4'h0, IDLE, SGL, 1'b1, 2'b11, NOSPL);
        applyStimulus(4'b0011, 4'h0, IDLE, SGL, 1'b1, 2'b00, NOSPL);
        checkOutput("split_away", 32'(hgrant_rr), 32'b0001);
        applyStimulus(4'b0010, 4'h0, IDLE, SGL, 1'b1, 2'b00, 64'h2);
        repeat (2) applyStimulus(4'b0010, 4'h0, IDLE, SGL, 1'b1, 2'b00, NOSPL);
        checkOutput("split_regrant", 32'(hgrant_rr), 32'b0010);

        // M3 holds HLOCK across several transfers while M0 and M1 request.
        $display("[TB] locked transfers");
        repeat (3) applyStimulus(4'b1000, 4'h0, IDLE, SGL, 1'b1, 2'b00, NOSPL);
        applyStimulus(4'b1011, 4'b1000, NSEQ, SGL, 1'b1, 2'b00, NOSPL);
        applyStimulus(4'b1011, 4'b1000, NSEQ, SGL, 1'b1, 2'b00, NOSPL);
        applyStimulus(4'b1011, 4'b1000, NSEQ, SGL, 1'b1, 2'b00, NOSPL);
        applyStimulus(4'b1011, 4'b1000, IDLE, SGL, 1'b1, 2'b00, NOSPL);
        checkOutput("lock_hold", 32'(hgrant_rr), 32'b1000);
        checkOutput("lock_flag", 32'(hmastlock_rr), 32'h1);
        applyStimulus(4'b1011, 4'b0000, IDLE, SGL, 1'b1, 2'b00, NOSPL);
        applyStimulus(4'b1011, 4'b0000, IDLE, SGL, 1'b1, 2'b00, NOSPL);
        checkOutput("lock_release", 32'(hgrant_rr), 32'b0001);

        // Asynchronous reset in the middle of an INCR16 burst.
        $display("[TB] reset mid-burst");
        applyStimulus(4'hF, 4'h0, NSEQ, INCR16, 1'b1, 2'b00, NOSPL);
        repeat (4) applyStimulus(4'hF, 4'h0, SEQ, INCR16, 1'b1, 2'b00, NOSPL);
        #2;
        hreset = 1'b1;
        #1;
        resetChecks("async");
        modelReset();
        @(posedge hclk);
        @(negedge hclk);
        hreset = 1'b0;

        // Randomised traffic against the model.
        $display("[TB] random traffic");
        for (int c = 0; c < 800; c++) begin
            logic           rdy;
            logic [1:0]     rsp;
            logic [NM-1:0]  lck;
            logic [NS*16-1:0] spl;
            rdy = ($urandom_range(0, 4) != 0);
            rsp = (!rdy && $urandom_range(0, 4) == 0) ? 2'b11 : 2'($urandom_range(0, 1));
            lck = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
            spl = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : NOSPL;
            applyStimulus(4'($urandom), lck, 2'($urandom), 3'($urandom), rdy, rsp, spl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
